regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_sb.sv | 62 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the register file with hazard scoreboard.
package regfile_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned R_DEF  = 8;
  localparam int unsigned AW_DEF = $clog2(R_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a write outstanding and flags
// double-issue hazards with a sticky error.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter  int unsigned R      = R_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(R)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue,
  input  logic [AW-1:0] Ino,
  input  logic          w,
  input  logic [AW-1:0] Wdno,
  input  logic [AW-1:0] Rdno,
  input  logic [AW-1:0] Rsno,
  output logic          stall,
  output logic          err
);

  localparam bit BYP = (BYPASS != 0);

  logic [R-1:0] busy;
  logic [R-1:0] busy_nx;
  logic [R-1:0] busy_eff;
  logic         hazard;

  always_comb begin
    busy_nx = busy;
    if (w)     busy_nx[Wdno] = 1'b0;
    // Issue is applied after the write so a same-cycle new producer wins.
    if (issue) busy_nx[Ino]  = 1'b1;
    busy_nx[0] = 1'b0;

    hazard = issue && (Ino != '0) && busy[Ino] && !(w && (Wdno == Ino));

    busy_eff = busy;
    if (BYP && w) busy_eff[Wdno] = 1'b0;
    busy_eff[0] = 1'b0;
  end

  assign stall = !reset && (busy_eff[Rdno] || busy_eff[Rsno]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nx;
      if (hazard) err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with r0 hardwired to zero, optional
// write-to-read forwarding, and a busy-bit scoreboard for stall/err.
module regfile_sb import regfile_pkg::*; #(
  parameter  int unsigned N      = N_DEF,
  parameter  int unsigned R      = R_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(R)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w,
  input  logic [AW-1:0] Wdno,
  input  logic [N-1:0]  Wdata,
  input  logic [AW-1:0] Rdno,
  input  logic [AW-1:0] Rsno,
  output logic [N-1:0]  Rd,
  output logic [N-1:0]  Rs,
  input  logic          issue,
  input  logic [AW-1:0] Ino,
  output logic          stall,
  output logic          err
);

  localparam bit BYP = (BYPASS != 0);

  logic [N-1:0] gpr [R];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr <= '{default: '0};
    end else if (w && (Wdno != '0)) begin
      gpr[Wdno] <= Wdata;
    end
  end

  // Reset gating keeps a forwarded Wdata from leaking out while reset is high.
  always_comb begin
    Rd = '0;
    Rs = '0;
    if (!reset && (Rdno != '0))
      Rd = (BYP && w && (Wdno == Rdno)) ? Wdata : gpr[Rdno];
    if (!reset && (Rsno != '0))
      Rs = (BYP && w && (Wdno == Rsno)) ? Wdata : gpr[Rsno];
  end

  regfile_scoreboard #(
    .R      (R),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk   (clk),
    .reset (reset),
    .issue (issue),
    .Ino   (Ino),
    .w     (w),
    .Wdno  (Wdno),
    .Rdno  (Rdno),
    .Rsno  (Rsno),
    .stall (stall),
    .err   (err)
  );

endmodule
